// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder iterated LSB-first over WIDTH bits.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             overflow_out
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_q;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    res_next = {fa_s, res_sr[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      carry_q      <= 1'b0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      sum_out      <= '0;
      carry_out    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      overflow_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            a_sr     <= a_in;
            b_sr     <= b_in;
            carry_q  <= c_in;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res_sr  <= res_next;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_q <= fa_co;
          // Counter stops at WIDTH-1; the state change, not a wrap, ends the op.
          if (last_bit) begin
            sum_out   <= res_next;
            carry_out <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q here is the carry into the MSB position.
            overflow_out <= carry_q ^ fa_co;
`endif
            done_out  <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
